sipo_word_ctrl: RTL and testbench

Frame controller that sequences serial-to-parallel word assembly. It accepts a frame-start strobe and qualified serial bits, counts exactly WIDTH accepted bits, and moves the finished word into a one-deep output register with a valid/ready handshake. It sits between a serial bit source and a parallel word consumer, and adds framing, abort/restart, backpressure and overrun detection around the shift datapath.

---
 rtl/sipo_word_ctrl.sv | 127 ++++++++++++
 tb/tb_sipo_word_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/sipo_word_ctrl.sv
// Serial-to-parallel frame controller: counts WIDTH qualified bits per frame and hands the
// finished word to a one-deep valid/ready output register, with abort, hold and overrun.
module sipo_word_ctrl #(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = 1'b0,
  localparam int unsigned CntW     = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             bit_valid_i,
  input  logic             bit_in_i,
  output logic [WIDTH-1:0] word_out_o,
  output logic             word_valid_o,
  input  logic             word_ready_i,
  output logic             busy_o,
  output logic [CntW-1:0]  bit_cnt_o,
  output logic             overrun_o,
  input  logic             clr_overrun_i
);

  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(WIDTH);

  typedef enum logic [1:0] {StIdle, StShift, StHold} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             valid_q, valid_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             overrun_q, overrun_d;

  logic             consume;
  logic             ovr_set;
  logic [WIDTH-1:0] shifted;

  assign consume = valid_q & word_ready_i;

  always_comb begin
    shifted = '0;
    if (MSB_FIRST) begin
      shifted = {sreg_q[WIDTH-2:0], bit_in_i};
    end else begin
      shifted = {bit_in_i, sreg_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    ovr_set = 1'b0;
    // A consumed word drops valid unless something below reloads it this edge.
    valid_d = valid_q & ~consume;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StShift;
          sreg_d  = '0;
          cnt_d   = '0;
        end
      end
      StShift: begin
        if (start_i) begin
          sreg_d = '0;
          cnt_d  = '0;
        end else if (bit_valid_i) begin
          if (cnt_q == LastCnt) begin
            if (!valid_q || word_ready_i) begin
              word_d  = shifted;
              valid_d = 1'b1;
              cnt_d   = '0;
              state_d = StIdle;
            end else begin
              sreg_d  = shifted;
              cnt_d   = FullCnt;
              state_d = StHold;
            end
          end else begin
            sreg_d = shifted;
            cnt_d  = cnt_q + CntW'(1);
          end
        end
      end
      StHold: begin
        ovr_set = bit_valid_i;
        if (consume) begin
          word_d  = sreg_q;
          valid_d = 1'b1;
          cnt_d   = '0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    overrun_d = ovr_set | (overrun_q & ~clr_overrun_i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      sreg_q    <= '0;
      word_q    <= '0;
      valid_q   <= 1'b0;
      cnt_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sreg_q    <= sreg_d;
      word_q    <= word_d;
      valid_q   <= valid_d;
      cnt_q     <= cnt_d;
      overrun_q <= overrun_d;
    end
  end

  assign word_out_o   = word_q;
  assign word_valid_o = valid_q;
  assign busy_o       = (state_q != StIdle);
  assign bit_cnt_o    = cnt_q;
  assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_sipo_word_ctrl.sv
// Directed bench for sipo_word_ctrl: LSB-first and MSB-first instances share one stimulus.
module tb_sipo_word_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_i = 1'b0;
  logic       bit_valid_i = 1'b0;
  logic       bit_in_i = 1'b0;
  logic       word_ready_i = 1'b0;
  logic       clr_overrun_i = 1'b0;

  logic [3:0] word0, word1;
  logic       valid0, valid1, busy0, busy1, ovr0, ovr1;
  logic [2:0] cnt0, cnt1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sipo_word_ctrl #(.WIDTH(4), .MSB_FIRST(1'b0)) dut0 (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .bit_valid_i  (bit_valid_i),
    .bit_in_i     (bit_in_i),
    .word_out_o   (word0),
    .word_valid_o (valid0),
    .word_ready_i (word_ready_i),
    .busy_o       (busy0),
    .bit_cnt_o    (cnt0),
    .overrun_o    (ovr0),
    .clr_overrun_i(clr_overrun_i)
  );

  sipo_word_ctrl #(.WIDTH(4), .MSB_FIRST(1'b1)) dut1 (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .bit_valid_i  (bit_valid_i),
    .bit_in_i     (bit_in_i),
    .word_out_o   (word1),
    .word_valid_o (valid1),
    .word_ready_i (word_ready_i),
    .busy_o       (busy1),
    .bit_cnt_o    (cnt1),
    .overrun_o    (ovr1),
    .clr_overrun_i(clr_overrun_i)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bit_valid_i = 1'b1;
    bit_in_i    = b;
    step();
    bit_valid_i = 1'b0;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    step();
    start_i = 1'b0;
  endtask

  initial begin
    logic [3:0] bits;
    logic [3:0] gbits;
    int         gap;

    // Reset state
    step();
    step();
    rst = 1'b0;
    step();
    check("rst_word", 32'(word0), 32'h0);
    check("rst_valid", 32'(valid0), 32'h0);
    check("rst_busy", 32'(busy0), 32'h0);
    check("rst_cnt", 32'(cnt0), 32'h0);
    check("rst_ovr", 32'(ovr0), 32'h0);

    // Basic frame 1,0,1,1 with ready high
    word_ready_i = 1'b1;
    pulse_start();
    check("start_busy", 32'(busy0), 32'h1);
    check("start_cnt", 32'(cnt0), 32'h0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    check("pre_last_valid", 32'(valid0), 32'h0);
    send_bit(1'b1);
    check("lsb_word", 32'(word0), 32'hD);
    check("lsb_valid", 32'(valid0), 32'h1);
    check("lsb_busy", 32'(busy0), 32'h0);
    check("lsb_cnt", 32'(cnt0), 32'h0);
    check("msb_word", 32'(word1), 32'hB);
    check("msb_valid", 32'(valid1), 32'h1);
    step();
    check("consumed_valid", 32'(valid0), 32'h0);

    // Asynchronous reset mid-cycle, mid-frame
    pulse_start();
    send_bit(1'b1);
    check("mid_cnt", 32'(cnt0), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_word", 32'(word0), 32'h0);
    check("arst_busy", 32'(busy0), 32'h0);
    check("arst_cnt", 32'(cnt0), 32'h0);
    step();
    rst = 1'b0;
    step();
    step();
    check("post_rst_busy", 32'(busy0), 32'h0);
    check("post_rst_word", 32'(word0), 32'h0);

    // Gapped input; bit_cnt steps 1,2,3 then 0
    gbits = 4'b1101;
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) step();
      send_bit(gbits[i]);
      check($sformatf("gap_cnt%0d", i), 32'(cnt0), (i == 3) ? 32'h0 : 32'(i + 1));
    end
    check("gap_word", 32'(word0), 32'hD);
    check("gap_valid", 32'(valid0), 32'h1);
    step();

    // Abort: start, 1,1, start, 0,1,1,0
    pulse_start();
    send_bit(1'b1);
    send_bit(1'b1);
    check("abort_cnt2", 32'(cnt0), 32'h2);
    pulse_start();
    check("abort_cnt0", 32'(cnt0), 32'h0);
    check("abort_busy", 32'(busy0), 32'h1);
    check("abort_novalid", 32'(valid0), 32'h0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    check("abort_pre_valid", 32'(valid0), 32'h0);
    send_bit(1'b0);
    check("abort_word", 32'(word0), 32'h6);
    check("abort_valid", 32'(valid0), 32'h1);
    step();

    // Backpressure: 0xA then 0x5 with ready low
    word_ready_i = 1'b0;
    bits = 4'hA;
    pulse_start();
    for (int i = 0; i < 4; i++) send_bit(bits[i]);
    check("bp_wordA", 32'(word0), 32'hA);
    check("bp_validA", 32'(valid0), 32'h1);
    check("bp_busyA", 32'(busy0), 32'h0);
    bits = 4'h5;
    pulse_start();
    for (int i = 0; i < 4; i++) send_bit(bits[i]);
    check("hold_busy", 32'(busy0), 32'h1);
    check("hold_cnt", 32'(cnt0), 32'h4);
    check("hold_word", 32'(word0), 32'hA);
    pulse_start();
    check("hold_start_ign", 32'(busy0), 32'h1);
    check("hold_ovr_clear", 32'(ovr0), 32'h0);
    send_bit(1'b1);
    check("hold_ovr_set", 32'(ovr0), 32'h1);
    check("hold_cnt_kept", 32'(cnt0), 32'h4);
    word_ready_i = 1'b1;
    step();
    word_ready_i = 1'b0;
    check("rel_word", 32'(word0), 32'h5);
    check("rel_valid", 32'(valid0), 32'h1);
    check("rel_busy", 32'(busy0), 32'h0);
    check("rel_cnt", 32'(cnt0), 32'h0);
    check("ovr_sticky", 32'(ovr0), 32'h1);
    clr_overrun_i = 1'b1;
    step();
    clr_overrun_i = 1'b0;
    check("ovr_cleared", 32'(ovr0), 32'h0);
    word_ready_i = 1'b1;
    step();
    check("rel_consumed", 32'(valid0), 32'h0);

    // Reset mid-SHIFT after two bits, then 0,0,0,1
    pulse_start();
    send_bit(1'b1);
    send_bit(1'b1);
    #2;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    step();
    pulse_start();
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    check("rst_frame_word", 32'(word0), 32'h8);
    check("rst_frame_valid", 32'(valid0), 32'h1);
    check("rst_frame_msb", 32'(word1), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
